mem_access: RTL and testbench
=============================

// Module: mem_access
// PURPOSE
//  Memory stage; consumer side of the execute->memory (ex_mem) interface. Takes the EX result (ALU value = address for ld/st),
//  runs the data-bus request/response handshake for loads/stores, and presents the mem_wb payload, MEM-stage forward and ok.
//  Non-memory instructions pass through with zero latency; loads/stores stall via ok=0 until the bus completes.
// PARAMETERS
//  XLEN        64   datapath width (word_t)
//  ILEN        32   instruction width
// PORTS
//  clk             in   1     clock, rising edge
//  rst_n           in   1     asynchronous active-low reset
//  ex_valid        in   1     ex_mem entry holds a live instruction
//  ex_inst         in   32    instruction bits (opcode/funct3 decoded locally)
//  ex_pc           in   64    instruction PC
//  ex_result       in   64    ALU result: writeback value, or effective address for ld/st
//  ex_store_data   in   64    rs2 value for stores
//  ex_rd           in   5     destination register
//  ex_wen          in   1     register write enable
//  advance         in   1     pipeline register update strobe (next stage consumes this cycle)
//  dreq_valid      out  1     data-bus request valid
//  dreq_addr       out  64    request address (ex_result, unmodified)
//  dreq_size       out  3     0=byte,1=half,2=word,3=dword
//  dreq_strobe     out  8     byte-write mask; 0 for loads
//  dreq_data       out  64    store data, shifted to byte lane addr[2:0]
//  dresp_data_ok   in   1     response strobe, one cycle
//  dresp_data      in   64    load data, aligned 8-byte word
//  wb_valid        out  1     mem_wb entry valid (= ex_valid & ok)
//  wb_inst/wb_pc   out  32/64 pass-through
//  wb_rd, wb_wen   out  5, 1  writeback target; wen forced 0 on misaligned
//  wb_data         out  64    load-extended data, or ex_result for non-loads
//  fwd_rd,fwd_wen,fwd_data out 5,1,64  forward; fwd_wen = wb_wen & ok
//  misalign        out  1     access addr not size-aligned (exception hook)
//  ok              out  1     stage finished current instruction this cycle
// BEHAVIOUR
//  - Decode: load = opcode 0000011, store = 0100011; funct3[1:0] = size, funct3[2]=1 -> zero-extend (lbu/lhu/lwu).
//  - Misaligned: addr[size-1:0]!=0. No bus request, ok=1, wb_wen=0, misalign=1. ex_valid=0 -> ok=1, no request.
//  - Non-memory valid: ok=1 same cycle, wb_data=ex_result; FSM untouched.
//  - FSM: IDLE, WAIT, DONE. Reset -> IDLE; dreq_valid=0, latched data=0, all outputs 0 except ok.
//    IDLE : ld/st valid aligned -> dreq_valid=1 combinationally; data_ok same cycle -> ok=1, go DONE
//           unless advance (stay IDLE); else -> WAIT.
//    WAIT : dreq_valid=1, addr/size/strobe/data held stable; on data_ok latch dresp_data, ok=1;
//           advance ? IDLE : DONE.
//    DONE : dreq_valid=0, ok=1 from latched data; advance -> IDLE. No second request for same instr.
//  - Load extract: shift dresp_data right by 8*addr[2:0], take size bytes, sign/zero extend to 64.
//  - Store: strobe = ((1<<(1<<size))-1) << addr[2:0]; dreq_data = ex_store_data << 8*addr[2:0].
//  - ok=0 only in IDLE (request issued, no data_ok) or WAIT w/o data_ok; upstream must hold ex_* stable.
//  - data_ok while IDLE with no request: ignored. Reset mid-WAIT: drop to IDLE, request deasserted.
//  - Latency: non-mem 0 cycles; mem = bus latency (0 extra cycles if data_ok in issue cycle).
// TESTING
//  1 add, ex_result=0x1234, wen=1 rd=5 -> ok=1 same cycle, wb_data=fwd_data=0x1234, dreq_valid=0.
//  2 lb addr=0x1003, dresp=0x00000000_80000000 after 3 cycles -> ok low 3 cycles, wb_data=0xFFFF_FFFF_FFFF_FF80.
//  3 sh addr=0x1006 data=0xABCD -> strobe=0xC0, dreq_data=0xABCD_0000_0000_0000, wb_wen=0.
//  4 lw addr=0x1002 -> misalign=1, ok=1, dreq_valid never rises, wb_wen=0.
//  5 ld, data_ok in cycle 2, advance=0 for 2 cycles -> DONE holds wb_data, no re-request; then IDLE.
//  6 rst_n low during WAIT -> dreq_valid=0 immediately, FSM IDLE; later data_ok ignored.

Source files
------------

// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory stage: data-bus handshake for loads/stores, mem_wb payload and forward
module mem_access #(
    parameter int XLEN = 64,
    parameter int ILEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic [ILEN-1:0] ex_inst,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_result,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic [4:0]      ex_rd,
    input  logic            ex_wen,
    input  logic            advance,
    output logic            dreq_valid,
    output logic [XLEN-1:0] dreq_addr,
    output logic [2:0]      dreq_size,
    output logic [7:0]      dreq_strobe,
    output logic [XLEN-1:0] dreq_data,
    input  logic            dresp_data_ok,
    input  logic [XLEN-1:0] dresp_data,
    output logic            wb_valid,
    output logic [ILEN-1:0] wb_inst,
    output logic [XLEN-1:0] wb_pc,
    output logic [4:0]      wb_rd,
    output logic            wb_wen,
    output logic [XLEN-1:0] wb_data,
    output logic [4:0]      fwd_rd,
    output logic            fwd_wen,
    output logic [XLEN-1:0] fwd_data,
    output logic            misalign,
    output logic            ok
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    state_t          state, state_next;
    logic [XLEN-1:0] resp_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [1:0] size;
    logic [2:0] offs;
    logic       is_load, is_store, mem_op, mis_raw, mem_go;
    logic       req_on, ok_int, take_resp;

    assign opcode   = ex_inst[6:0];
    assign funct3   = ex_inst[14:12];
    assign size     = funct3[1:0];
    assign offs     = ex_result[2:0];
    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign mem_op   = ex_valid & (is_load | is_store);

    always_comb begin
        mis_raw = 1'b0;
        case (size)
            2'd0: mis_raw = 1'b0;
            2'd1: mis_raw = offs[0];
            2'd2: mis_raw = |offs[1:0];
            2'd3: mis_raw = |offs;
            default: mis_raw = 1'b0;
        endcase
    end

    assign mem_go = mem_op & ~mis_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            resp_q <= '0;
        end else begin
            state <= state_next;
            if (take_resp) begin
                resp_q <= dresp_data;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (mem_go) begin
                    if (dresp_data_ok) state_next = advance ? S_IDLE : S_DONE;
                    else               state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dresp_data_ok) state_next = advance ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                if (advance) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // A response is only meaningful while a request is actually outstanding.
    always_comb begin
        req_on    = 1'b0;
        ok_int    = 1'b1;
        take_resp = 1'b0;
        case (state)
            S_IDLE: begin
                req_on    = mem_go;
                ok_int    = mem_go ? dresp_data_ok : 1'b1;
                take_resp = mem_go & dresp_data_ok;
            end
            S_WAIT: begin
                req_on    = 1'b1;
                ok_int    = dresp_data_ok;
                take_resp = dresp_data_ok;
            end
            S_DONE: begin
                req_on    = 1'b0;
                ok_int    = 1'b1;
            end
            default: begin
                req_on    = 1'b0;
                ok_int    = 1'b1;
            end
        endcase
    end

    logic [7:0]      size_mask;
    logic [XLEN-1:0] load_src, load_shifted, load_ext;

    always_comb begin
        size_mask = 8'h00;
        case (size)
            2'd0: size_mask = 8'h01;
            2'd1: size_mask = 8'h03;
            2'd2: size_mask = 8'h0F;
            2'd3: size_mask = 8'hFF;
            default: size_mask = 8'h00;
        endcase
    end

    assign load_src     = (state == S_DONE) ? resp_q : dresp_data;
    assign load_shifted = load_src >> {offs, 3'b000};

    always_comb begin
        load_ext = load_shifted;
        case (size)
            2'd0: load_ext = funct3[2] ? {{(XLEN-8){1'b0}}, load_shifted[7:0]}
                                       : {{(XLEN-8){load_shifted[7]}}, load_shifted[7:0]};
            2'd1: load_ext = funct3[2] ? {{(XLEN-16){1'b0}}, load_shifted[15:0]}
                                       : {{(XLEN-16){load_shifted[15]}}, load_shifted[15:0]};
            2'd2: load_ext = funct3[2] ? {{(XLEN-32){1'b0}}, load_shifted[31:0]}
                                       : {{(XLEN-32){load_shifted[31]}}, load_shifted[31:0]};
            2'd3: load_ext = load_shifted;
            default: load_ext = load_shifted;
        endcase
    end

    // Request is gated by reset so an in-flight access drops the instant reset asserts.
    assign dreq_valid  = rst_n & req_on;
    assign dreq_addr   = ex_result;
    assign dreq_size   = {1'b0, size};
    assign dreq_strobe = is_store ? (size_mask << offs) : 8'h00;
    assign dreq_data   = ex_store_data << {offs, 3'b000};

    assign ok       = ok_int;
    assign misalign = mem_op & mis_raw;
    assign wb_valid = ex_valid & ok_int;
    assign wb_inst  = ex_inst;
    assign wb_pc    = ex_pc;
    assign wb_rd    = ex_rd;
    assign wb_wen   = ex_valid & ex_wen & ~misalign;
    assign wb_data  = is_load ? load_ext : ex_result;
    assign fwd_rd   = ex_rd;
    assign fwd_wen  = wb_wen & ok_int;
    assign fwd_data = wb_data;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed scoreboard bench for mem_access
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [31:0] ex_inst;
    logic [63:0] ex_pc, ex_result, ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_wen, advance;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;
    logic        wb_valid;
    logic [31:0] wb_inst;
    logic [63:0] wb_pc;
    logic [4:0]  wb_rd;
    logic        wb_wen;
    logic [63:0] wb_data;
    logic [4:0]  fwd_rd;
    logic        fwd_wen;
    logic [63:0] fwd_data;
    logic        misalign, ok;

    always #5 clk = ~clk;

    mem_access dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_inst(ex_inst), .ex_pc(ex_pc),
        .ex_result(ex_result), .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_wen(ex_wen),
        .advance(advance), .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data), .dresp_data_ok(dresp_data_ok),
        .dresp_data(dresp_data), .wb_valid(wb_valid), .wb_inst(wb_inst), .wb_pc(wb_pc),
        .wb_rd(wb_rd), .wb_wen(wb_wen), .wb_data(wb_data), .fwd_rd(fwd_rd), .fwd_wen(fwd_wen),
        .fwd_data(fwd_data), .misalign(misalign), .ok(ok)
    );

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_ALU = 7'b0110011;

    typedef struct {
        string       tag;
        logic [63:0] data;
        logic        wen;
        logic        mis;
        logic        chkd;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
        return {17'd0, f3, 5'd0, op};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] inst, input logic [63:0] res, input logic [63:0] sdata,
                         input logic [4:0] rd, input logic wen, input logic adv);
        ex_valid      = 1'b1;
        ex_inst       = inst;
        ex_pc         = 64'h8000_0000 + {32'd0, inst};
        ex_result     = res;
        ex_store_data = sdata;
        ex_rd         = rd;
        ex_wen        = wen;
        advance       = adv;
    endtask

    task automatic push(input string tag, input logic [63:0] d, input logic w, input logic m,
                        input logic cd);
        exp_t e;
        e.tag = tag; e.data = d; e.wen = w; e.mis = m; e.chkd = cd;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty observed=0 entries expected=1 entry");
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_ok"}, {63'd0, ok}, 64'd1);
            chk({e.tag, "_wb_valid"}, {63'd0, wb_valid}, 64'd1);
            if (e.chkd) chk({e.tag, "_wb_data"}, wb_data, e.data);
            chk({e.tag, "_wb_wen"}, {63'd0, wb_wen}, {63'd0, e.wen});
            chk({e.tag, "_misalign"}, {63'd0, misalign}, {63'd0, e.mis});
        end
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; ex_inst = '0; ex_pc = '0; ex_result = '0;
        ex_store_data = '0; ex_rd = '0; ex_wen = 1'b0; advance = 1'b0;
        dresp_data_ok = 1'b0; dresp_data = '0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_dreq_valid", {63'd0, dreq_valid}, 64'd0);
        chk("rst_ok", {63'd0, ok}, 64'd1);
        chk("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
        chk("rst_fwd_wen", {63'd0, fwd_wen}, 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // 1: ALU op passes through with zero latency
        drive(mk(OP_ALU, 3'b000), 64'h1234, 64'd0, 5'd5, 1'b1, 1'b1);
        push("add", 64'h1234, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        pop_check();
        chk("add_fwd_data", fwd_data, 64'h1234);
        chk("add_fwd_wen", {63'd0, fwd_wen}, 64'd1);
        chk("add_fwd_rd", {59'd0, fwd_rd}, 64'd5);
        chk("add_dreq_valid", {63'd0, dreq_valid}, 64'd0);
        step();

        // 2: lb with 3 stall cycles, sign-extended byte
        drive(mk(OP_LD, 3'b000), 64'h1003, 64'd0, 5'd6, 1'b1, 1'b1);
        push("lb", 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("lb_stall%0d_ok", i), {63'd0, ok}, 64'd0);
            chk($sformatf("lb_stall%0d_dreq", i), {63'd0, dreq_valid}, 64'd1);
            step();
        end
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h0000_0000_8000_0000;
        @(negedge clk);
        pop_check();
        chk("lb_dreq_strobe", {56'd0, dreq_strobe}, 64'd0);
        step();
        dresp_data_ok = 1'b0;
        ex_valid      = 1'b0;

        // 3: sh into the top half-word lane, response in the issue cycle
        drive(mk(OP_ST, 3'b001), 64'h1006, 64'hABCD, 5'd0, 1'b0, 1'b1);
        push("sh", 64'h1006, 1'b0, 1'b0, 1'b1);
        dresp_data_ok = 1'b1;
        @(negedge clk);
        chk("sh_dreq_valid", {63'd0, dreq_valid}, 64'd1);
        chk("sh_strobe", {56'd0, dreq_strobe}, 64'hC0);
        chk("sh_dreq_data", dreq_data, 64'hABCD_0000_0000_0000);
        chk("sh_dreq_size", {61'd0, dreq_size}, 64'd1);
        pop_check();
        step();
        dresp_data_ok = 1'b0;

        // 4: misaligned lw never requests the bus
        drive(mk(OP_LD, 3'b010), 64'h1002, 64'd0, 5'd7, 1'b1, 1'b1);
        push("lw_mis", 64'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("lw_mis_dreq", {63'd0, dreq_valid}, 64'd0);
        pop_check();
        step();
        @(negedge clk);
        chk("lw_mis_dreq_later", {63'd0, dreq_valid}, 64'd0);
        step();

        // lhu: zero extension of a negative half-word
        drive(mk(OP_LD, 3'b101), 64'h4002, 64'd0, 5'd8, 1'b1, 1'b1);
        push("lhu", 64'h0000_0000_0000_8001, 1'b1, 1'b0, 1'b1);
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h0000_0000_8001_0000;
        @(negedge clk);
        pop_check();
        step();
        dresp_data_ok = 1'b0;

        // 5: ld completes while next stage is stalled; DONE holds data without re-request
        drive(mk(OP_LD, 3'b011), 64'h2000, 64'd0, 5'd9, 1'b1, 1'b0);
        push("ld", 64'h1122_3344_5566_7788, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("ld_issue_ok", {63'd0, ok}, 64'd0);
        step();
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h1122_3344_5566_7788;
        @(negedge clk);
        pop_check();
        step();
        dresp_data_ok = 1'b0;
        dresp_data    = 64'hDEAD_BEEF_DEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("ld_done%0d_dreq", i), {63'd0, dreq_valid}, 64'd0);
            chk($sformatf("ld_done%0d_ok", i), {63'd0, ok}, 64'd1);
            chk($sformatf("ld_done%0d_data", i), wb_data, 64'h1122_3344_5566_7788);
            chk($sformatf("ld_done%0d_fwd_wen", i), {63'd0, fwd_wen}, 64'd1);
            step();
        end
        advance = 1'b1;
        step();
        ex_valid = 1'b0;

        // 6: reset asserted while waiting on the bus
        drive(mk(OP_LD, 3'b011), 64'h3000, 64'd0, 5'd10, 1'b1, 1'b1);
        @(negedge clk);
        chk("rw_issue_ok", {63'd0, ok}, 64'd0);
        step();
        @(negedge clk);
        chk("rw_wait_dreq", {63'd0, dreq_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rw_rst_dreq", {63'd0, dreq_valid}, 64'd0);
        ex_valid = 1'b0;
        step();
        rst_n         = 1'b1;
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h5555_5555_5555_5555;
        @(negedge clk);
        chk("rw_stray_ok", {63'd0, ok}, 64'd1);
        chk("rw_stray_wb_valid", {63'd0, wb_valid}, 64'd0);
        step();
        dresp_data_ok = 1'b0;
        drive(mk(OP_LD, 3'b011), 64'h3008, 64'd0, 5'd11, 1'b1, 1'b1);
        push("ld_post_rst", 64'h0BAD_F00D_0000_0042, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("rw_idle_dreq", {63'd0, dreq_valid}, 64'd1);
        chk("rw_idle_ok", {63'd0, ok}, 64'd0);
        step();
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h0BAD_F00D_0000_0042;
        @(negedge clk);
        pop_check();
        step();
        dresp_data_ok = 1'b0;
        ex_valid      = 1'b0;

        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
